// File: rtl/wb_commit_regfile.sv
// Writeback/commit stage: 32 x XLEN register file, retired-instruction counter, trap halt.
// Latency: reads are combinational with WB->ID bypass; commit_* outputs are registered one cycle after commit.
// Backpressure: none; a valid WB instruction commits in the cycle it is presented unless the core is halted.
module wb_commit_regfile #(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid_i,
  input  logic                 wb_inst_nop_i,
  input  logic                 wb_rd_en_i,
  input  logic [REG_IDX_W-1:0] wb_rd_index_i,
  input  logic [XLEN-1:0]      wb_rd_data_i,
  input  logic                 wb_inst_trap_i,
  input  logic [REG_IDX_W-1:0] rs1_index_i,
  input  logic [REG_IDX_W-1:0] rs2_index_i,
  output logic [XLEN-1:0]      rs1_data_o,
  output logic [XLEN-1:0]      rs2_data_o,
  output logic                 commit_o,
  output logic                 commit_rd_en_o,
  output logic [REG_IDX_W-1:0] commit_rd_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 halted_o,
  output logic [XLEN-1:0]      trap_code_o
);

  localparam int NREGS = 1 << REG_IDX_W;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // a0 holds the exit code when the trap instruction retires
  localparam logic [REG_IDX_W-1:0] A0_IDX = REG_IDX_W'(10);

  logic [XLEN-1:0]      r_regs [NREGS];
  logic [0:0]           r_state;
  logic [INSTRET_W-1:0] r_instret;
  logic [XLEN-1:0]      r_trap_code;
  logic                 r_commit;
  logic                 r_commit_rd_en;
  logic [REG_IDX_W-1:0] r_commit_rd;

  logic                 w_fire;
  logic                 w_wr;
  logic [XLEN-1:0]      w_rs1;
  logic [XLEN-1:0]      w_rs2;
  logic [XLEN-1:0]      w_a0;

  assign w_fire = wb_valid_i & ~wb_inst_nop_i & (r_state == ST_RUN);
  assign w_wr   = w_fire & wb_rd_en_i & (wb_rd_index_i != '0);

  // Read port 1: x0 is zero, an in-flight WB write to the same index wins over the array
  always_comb begin
    w_rs1 = r_regs[rs1_index_i];
    if (rs1_index_i == '0) begin
      w_rs1 = '0;
    end else if (w_wr && (wb_rd_index_i == rs1_index_i)) begin
      w_rs1 = wb_rd_data_i;
    end
  end

  // Read port 2: same zero/bypass rule as port 1
  always_comb begin
    w_rs2 = r_regs[rs2_index_i];
    if (rs2_index_i == '0) begin
      w_rs2 = '0;
    end else if (w_wr && (wb_rd_index_i == rs2_index_i)) begin
      w_rs2 = wb_rd_data_i;
    end
  end

  // a0 as seen by the trap instruction itself, so a trap that also writes a0 reports the new value
  always_comb begin
    w_a0 = r_regs[A0_IDX];
    if (w_wr && (wb_rd_index_i == A0_IDX)) begin
      w_a0 = wb_rd_data_i;
    end
  end

  // Register file array; x0 entry is never written so it stays at its reset value of zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[wb_rd_index_i] <= wb_rd_data_i;
    end
  end

  // Run/halt state machine and trap exit-code capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_trap_code <= '0;
    end else if (w_fire && wb_inst_trap_i) begin
      r_state     <= ST_HALT;
      r_trap_code <= w_a0;
    end
  end

  // Retired-instruction counter; wraps silently at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (w_fire) begin
      r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  // One-cycle commit report; rd index is captured only for real commits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit       <= 1'b0;
      r_commit_rd_en <= 1'b0;
      r_commit_rd    <= '0;
    end else begin
      r_commit       <= w_fire;
      r_commit_rd_en <= w_wr;
      if (w_fire) begin
        r_commit_rd <= wb_rd_index_i;
      end
    end
  end

  assign rs1_data_o     = w_rs1;
  assign rs2_data_o     = w_rs2;
  assign commit_o       = r_commit;
  assign commit_rd_en_o = r_commit_rd_en;
  assign commit_rd_o    = r_commit_rd;
  assign instret_o      = r_instret;
  assign halted_o       = (r_state == ST_HALT);
  assign trap_code_o    = r_trap_code;

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Bench for wb_commit_regfile: directed literal cases plus randomized traffic against a behavioural model.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
// Outputs are compared on every falling edge once the first reset has been seen.
module tb_wb_commit_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_nop, wb_rd_en, wb_trap;
  logic [4:0]  wb_rd, rs1_idx, rs2_idx;
  logic [63:0] wb_data;

  logic [63:0] rs1_data, rs2_data, instret, trap_code;
  logic        commit, commit_rd_en, halted;
  logic [4:0]  commit_rd;

  logic [63:0] s_rs1, s_rs2, s_trap_code;
  logic        s_commit, s_commit_rd_en, s_halted;
  logic [4:0]  s_commit_rd;
  logic [3:0]  s_instret;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_commit_regfile u_dut (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid), .wb_inst_nop_i(wb_nop), .wb_rd_en_i(wb_rd_en),
    .wb_rd_index_i(wb_rd), .wb_rd_data_i(wb_data), .wb_inst_trap_i(wb_trap),
    .rs1_index_i(rs1_idx), .rs2_index_i(rs2_idx),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
    .commit_o(commit), .commit_rd_en_o(commit_rd_en), .commit_rd_o(commit_rd),
    .instret_o(instret), .halted_o(halted), .trap_code_o(trap_code)
  );

  wb_commit_regfile #(.INSTRET_W(4)) u_small (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid), .wb_inst_nop_i(wb_nop), .wb_rd_en_i(wb_rd_en),
    .wb_rd_index_i(wb_rd), .wb_rd_data_i(wb_data), .wb_inst_trap_i(wb_trap),
    .rs1_index_i(rs1_idx), .rs2_index_i(rs2_idx),
    .rs1_data_o(s_rs1), .rs2_data_o(s_rs2),
    .commit_o(s_commit), .commit_rd_en_o(s_commit_rd_en), .commit_rd_o(s_commit_rd),
    .instret_o(s_instret), .halted_o(s_halted), .trap_code_o(s_trap_code)
  );

  // ---------------- behavioural model ----------------
  logic [63:0] m_regs [32];
  logic [63:0] m_instret;
  logic [63:0] m_trap;
  bit          m_halted, m_commit, m_crd_en, m_ok;
  logic [4:0]  m_crd;

  // Architectural value of register idx as decode sees it right now
  function automatic logic [63:0] mread(input logic [4:0] idx);
    bit committing;
    committing = wb_valid && !wb_nop && !m_halted;
    if (idx == 5'd0) return 64'd0;
    if (committing && wb_rd_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  always @(posedge clk) begin
    logic [63:0] a0;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_instret = 64'd0;
      m_trap    = 64'd0;
      m_halted  = 1'b0;
      m_commit  = 1'b0;
      m_crd_en  = 1'b0;
      m_crd     = 5'd0;
      m_ok      = 1'b1;
    end else if (wb_valid && !wb_nop && !m_halted) begin
      a0        = mread(5'd10);
      m_commit  = 1'b1;
      m_crd_en  = wb_rd_en && (wb_rd != 5'd0);
      m_crd     = wb_rd;
      m_instret = m_instret + 64'd1;
      if (wb_trap) begin
        m_halted = 1'b1;
        m_trap   = a0;
      end
      if (m_crd_en) m_regs[wb_rd] = wb_data;
    end else begin
      m_commit = 1'b0;
      m_crd_en = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (m_ok) begin
      chk("rs1_data", rs1_data, mread(rs1_idx));
      chk("rs2_data", rs2_data, mread(rs2_idx));
      chk("commit", {63'd0, commit}, {63'd0, m_commit});
      chk("commit_rd_en", {63'd0, commit_rd_en}, {63'd0, m_crd_en});
      if (m_commit) chk("commit_rd", {59'd0, commit_rd}, {59'd0, m_crd});
      chk("instret", instret, m_instret);
      chk("halted", {63'd0, halted}, {63'd0, m_halted});
      chk("trap_code", trap_code, m_trap);
      chk("small_instret", {60'd0, s_instret}, {60'd0, m_instret[3:0]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wb_valid = 1'b0; wb_nop = 1'b0; wb_rd_en = 1'b0; wb_trap = 1'b0;
  endtask

  task automatic step(input bit v, input bit nop, input bit en, input logic [4:0] rd,
                      input logic [63:0] d, input bit tr);
    wb_valid = v; wb_nop = nop; wb_rd_en = en; wb_rd = rd; wb_data = d; wb_trap = tr;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    wb_rd = 5'd0; wb_data = 64'd0; rs1_idx = 5'd3; rs2_idx = 5'd0;
    do_reset();

    // Reset state
    chk("rst_instret", instret, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_commit", {63'd0, commit}, 64'd0);
    chk("rst_x3", rs1_data, 64'd0);

    // Write x5 then read it back next cycle
    step(1, 0, 1, 5'd5, 64'hDEAD_BEEF, 0);
    chk("w5_commit", {63'd0, commit}, 64'd1);
    chk("w5_commit_rd", {59'd0, commit_rd}, 64'd5);
    chk("w5_instret", instret, 64'd1);
    rs1_idx = 5'd5; #1;
    chk("w5_read", rs1_data, 64'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("w5_pulse_ends", {63'd0, commit}, 64'd0);

    // Same-cycle bypass on port 2
    wb_valid = 1; wb_rd_en = 1; wb_rd = 5'd7; wb_data = 64'h1234; rs2_idx = 5'd7; #1;
    chk("bypass_x7", rs2_data, 64'h1234);
    @(posedge clk); #1; idle();

    // Write to x0 is dropped but still retires
    step(1, 0, 1, 5'd0, 64'hFFFF, 0);
    rs1_idx = 5'd0; #1;
    chk("x0_read", rs1_data, 64'd0);
    chk("x0_rd_en", {63'd0, commit_rd_en}, 64'd0);
    chk("x0_instret", instret, 64'd3);

    // Bubble does not write or count
    step(1, 0, 1, 5'd3, 64'hAAAA, 0);
    step(1, 1, 1, 5'd3, 64'h5555, 0);
    rs1_idx = 5'd3; #1;
    chk("nop_x3", rs1_data, 64'hAAAA);
    chk("nop_commit", {63'd0, commit}, 64'd0);
    chk("nop_instret", instret, 64'd4);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 0, 0, 5'd1, 64'd0, 0);
    chk("wrap_pre", {60'd0, s_instret}, 64'd15);
    step(1, 0, 0, 5'd1, 64'd0, 0);
    chk("wrap_post", {60'd0, s_instret}, 64'd0);
    chk("wide_16", instret, 64'd16);

    // Trap with a0 = 0, then writes ignored, then reset recovers
    do_reset();
    step(1, 0, 1, 5'd1, 64'h11, 0);
    step(1, 0, 1, 5'd10, 64'h0, 0);
    step(1, 0, 0, 5'd0, 64'd0, 1);
    chk("trap_halted", {63'd0, halted}, 64'd1);
    chk("trap_code0", trap_code, 64'd0);
    chk("trap_instret", instret, 64'd3);
    step(1, 0, 1, 5'd1, 64'h99, 0);
    rs1_idx = 5'd1; #1;
    chk("halt_x1", rs1_data, 64'h11);
    chk("halt_instret", instret, 64'd3);
    chk("halt_commit", {63'd0, commit}, 64'd0);
    do_reset();
    chk("unhalt", {63'd0, halted}, 64'd0);
    chk("unhalt_x1", rs1_data, 64'd0);

    // Trap that writes a0 in the same instruction reports the new value
    step(1, 0, 1, 5'd10, 64'h77, 0);
    step(1, 0, 1, 5'd10, 64'h99, 1);
    chk("trap_bypass_a0", trap_code, 64'h99);
    rs1_idx = 5'd10; #1;
    chk("trap_wrote_a0", rs1_data, 64'h99);
    do_reset();

    // Randomized traffic, occasional trap and reset
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      wb_valid = ($urandom_range(0, 9) < 7);
      wb_nop   = ($urandom_range(0, 6) == 0);
      wb_rd_en = ($urandom_range(0, 4) != 0);
      wb_rd    = 5'($urandom_range(0, 31));
      wb_data  = {$urandom, $urandom};
      wb_trap  = ($urandom_range(0, 59) == 0);
      rs1_idx  = ($urandom_range(0, 2) == 0) ? wb_rd : 5'($urandom_range(0, 31));
      rs2_idx  = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    rst = 1'b0; idle();
    @(posedge clk); #1;
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
